// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - opcodes, control bundles and instruction field positions for the MIPS front end
package pipeline_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // WB: {RegWrite, WBsel}, ME: {Branch, MemRead, MemWrite}, EX: {RegDst, ALUOp1, ALUOp0, ALUSrc}
    localparam logic [1:0] CTRL_WB_NONE = 2'b00;
    localparam logic [1:0] CTRL_WB_ALU  = 2'b11;
    localparam logic [1:0] CTRL_WB_MEM  = 2'b10;

    localparam logic [2:0] CTRL_ME_NONE   = 3'b000;
    localparam logic [2:0] CTRL_ME_BRANCH = 3'b100;
    localparam logic [2:0] CTRL_ME_LOAD   = 3'b010;
    localparam logic [2:0] CTRL_ME_STORE  = 3'b001;

    localparam logic [3:0] CTRL_EX_NONE   = 4'b0000;
    localparam logic [3:0] CTRL_EX_RTYPE  = 4'b0100;
    localparam logic [3:0] CTRL_EX_IMM_RT = 4'b1001;
    localparam logic [3:0] CTRL_EX_STORE  = 4'b0001;
    localparam logic [3:0] CTRL_EX_BRANCH = 4'b0010;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;

    typedef struct packed {
        logic [1:0] wb;
        logic [2:0] me;
        logic [3:0] ex;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '{wb: CTRL_WB_NONE, me: CTRL_ME_NONE, ex: CTRL_EX_NONE};

    // Opcodes whose rt field is a source operand rather than a destination
    function automatic logic reads_rt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
    endfunction

endpackage

// File: rtl/main_control.sv
// rtl/main_control.sv - combinational opcode to WB/ME/EX control bundle decoder
module main_control
    import pipeline_pkg::*;
(
    input  logic [5:0] opcode_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = CTRL_NONE;
        unique case (opcode_i)
            OP_RTYPE: ctrl_o = '{wb: CTRL_WB_ALU,  me: CTRL_ME_NONE,   ex: CTRL_EX_RTYPE};
            OP_LW:    ctrl_o = '{wb: CTRL_WB_MEM,  me: CTRL_ME_LOAD,   ex: CTRL_EX_IMM_RT};
            OP_SW:    ctrl_o = '{wb: CTRL_WB_NONE, me: CTRL_ME_STORE,  ex: CTRL_EX_STORE};
            OP_BEQ:   ctrl_o = '{wb: CTRL_WB_NONE, me: CTRL_ME_BRANCH, ex: CTRL_EX_BRANCH};
            OP_ADDI:  ctrl_o = '{wb: CTRL_WB_ALU,  me: CTRL_ME_NONE,   ex: CTRL_EX_IMM_RT};
            default:  ctrl_o = CTRL_NONE;
        endcase
    end

endmodule

// File: rtl/fetch_decode_stage.sv
// rtl/fetch_decode_stage.sv - PC, IF/ID register, decode, load-use stall and branch redirect
module fetch_decode_stage
    import pipeline_pkg::*;
#(
    parameter int          IMEM_AW  = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    input  logic               ex_mem_read,
    input  logic [4:0]         ex_rt,
    output logic [31:0]        instr,
    output logic [4:0]         read0,
    output logic [4:0]         read1,
    output logic [4:0]         write,
    output logic [1:0]         WBID,
    output logic [2:0]         MEID,
    output logic [3:0]         EXID,
    output logic [31:0]        pc_id,
    output logic               stall,
    output logic               flush
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic        id_valid_q, id_valid_d;

    logic [31:0] pc_plus4;
    logic [5:0]  opcode;
    logic        hazard;
    ctrl_t       ctrl_dec;

    assign pc_plus4  = pc_q + 32'd4;
    assign imem_addr = pc_q[IMEM_AW+1:2];

    assign opcode = instr_q[OPC_MSB:OPC_LSB];
    assign instr  = instr_q;
    assign read0  = instr_q[RS_MSB:RS_LSB];
    assign read1  = instr_q[RT_MSB:RT_LSB];
    assign write  = instr_q[RD_MSB:RD_LSB];
    assign pc_id  = pc_id_q;

    main_control u_main_control (
        .opcode_i (opcode),
        .ctrl_o   (ctrl_dec)
    );

    assign hazard = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == read0) || ((ex_rt == read1) && reads_rt(opcode)));

    // A taken branch squashes ID anyway, so the bubble is not needed then
    assign stall = hazard && !branch_taken;
    assign flush = branch_taken;

    always_comb begin
        if (!id_valid_q || stall || branch_taken) begin
            {WBID, MEID, EXID} = CTRL_NONE;
        end else begin
            {WBID, MEID, EXID} = ctrl_dec;
        end
    end

    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_id_d    = pc_id_q;
        id_valid_d = id_valid_q;
        if (branch_taken) begin
            pc_d       = branch_target & ~32'd3;
            instr_d    = NOP_WORD;
            id_valid_d = 1'b0;
        end else if (!stall) begin
            pc_d       = pc_plus4;
            instr_d    = imem_data;
            pc_id_d    = pc_plus4;
            id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            instr_q    <= NOP_WORD;
            pc_id_q    <= 32'd0;
            id_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_id_q    <= pc_id_d;
            id_valid_q <= id_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb/tb_fetch_decode_stage.sv - directed self-checking bench for fetch_decode_stage
module tb_fetch_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic [31:0] instr;
    logic [4:0]  read0, read1, write;
    logic [1:0]  WBID;
    logic [2:0]  MEID;
    logic [3:0]  EXID;
    logic [31:0] pc_id;
    logic        stall, flush;

    logic [31:0] mem [0:1023];
    int n_cmp = 0;
    int n_bad = 0;

    assign imem_data = mem[imem_addr];

    always #5 clk = ~clk;

    fetch_decode_stage #(.IMEM_AW(10), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .ex_mem_read   (ex_mem_read),
        .ex_rt         (ex_rt),
        .instr         (instr),
        .read0         (read0),
        .read1         (read1),
        .write         (write),
        .WBID          (WBID),
        .MEID          (MEID),
        .EXID          (EXID),
        .pc_id         (pc_id),
        .stall         (stall),
        .flush         (flush)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        ex_mem_read = 1'b0; ex_rt = 5'd0;
        tick(); tick();
        n_cmp++; if (imem_addr !== 10'd0) begin n_bad++; $display("FAIL reset_imem_addr got %h exp 0", imem_addr); end
        n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr got %h exp 0", instr); end
        n_cmp++; if ({WBID, MEID, EXID} !== 9'b0) begin n_bad++; $display("FAIL reset_ctrl got %b exp 0", {WBID, MEID, EXID}); end
        n_cmp++; if ({stall, flush} !== 2'b00) begin n_bad++; $display("FAIL reset_stall_flush got %b exp 00", {stall, flush}); end
        n_cmp++; if (pc_id !== 32'h0) begin n_bad++; $display("FAIL reset_pc_id got %h exp 0", pc_id); end
    endtask

    task automatic test_fetch_decode();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (instr !== 32'h00221820) begin n_bad++; $display("FAIL fd_instr got %h exp 00221820", instr); end
        n_cmp++; if ({read0, read1, write} !== {5'd1, 5'd2, 5'd3}) begin n_bad++; $display("FAIL fd_regs got %0d %0d %0d exp 1 2 3", read0, read1, write); end
        n_cmp++; if ({WBID, MEID, EXID} !== 9'b11_000_0100) begin n_bad++; $display("FAIL fd_add_ctrl got %b exp 110000100", {WBID, MEID, EXID}); end
        n_cmp++; if ({pc_id, 22'd0, imem_addr} !== {32'd4, 32'd1}) begin n_bad++; $display("FAIL fd_pc got pc_id %h addr %h exp 4 1", pc_id, imem_addr); end
    endtask

    task automatic test_load_use();
        ex_mem_read = 1'b1; ex_rt = 5'd2; #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall got %b exp 1", stall); end
        n_cmp++; if ({WBID, MEID, EXID} !== 9'b0) begin n_bad++; $display("FAIL lu_bubble got %b exp 0", {WBID, MEID, EXID}); end
        tick();
        n_cmp++; if ({imem_addr, instr} !== {10'd1, 32'h00221820}) begin n_bad++; $display("FAIL lu_hold got addr %h instr %h exp 1 00221820", imem_addr, instr); end
        ex_rt = 5'd0; #1;
        n_cmp++; if ({stall, WBID, MEID, EXID} !== 10'b0_11_000_0100) begin n_bad++; $display("FAIL lu_rt0 got %b exp 0110000100", {stall, WBID, MEID, EXID}); end
        ex_mem_read = 1'b0;
        tick();
        n_cmp++; if ({WBID, MEID, EXID} !== 9'b10_010_1001) begin n_bad++; $display("FAIL lw_ctrl got %b exp 100101001", {WBID, MEID, EXID}); end
        n_cmp++; if ({pc_id, 22'd0, imem_addr} !== {32'd8, 32'd2}) begin n_bad++; $display("FAIL lw_pc got pc_id %h addr %h exp 8 2", pc_id, imem_addr); end
        ex_mem_read = 1'b1; ex_rt = 5'd2; #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lw_rt_nosrc got %b exp 0", stall); end
        ex_mem_read = 1'b0;
    endtask

    task automatic test_addi_store_hazard();
        tick();
        ex_mem_read = 1'b1; ex_rt = 5'd2; #1;
        n_cmp++; if ({stall, WBID, MEID, EXID} !== 10'b0_11_000_1001) begin n_bad++; $display("FAIL addi_rt got %b exp 0110001001", {stall, WBID, MEID, EXID}); end
        ex_rt = 5'd5; #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL addi_rs got %b exp 1", stall); end
        ex_mem_read = 1'b0; ex_rt = 5'd0;
        tick();
        ex_mem_read = 1'b1; ex_rt = 5'd2; #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL sw_rt got %b exp 1", stall); end
        ex_mem_read = 1'b0; #1;
        n_cmp++; if ({stall, WBID, MEID, EXID} !== 10'b0_00_001_0001) begin n_bad++; $display("FAIL sw_ctrl got %b exp 0000010001", {stall, WBID, MEID, EXID}); end
    endtask

    task automatic test_branch();
        branch_taken = 1'b1; branch_target = 32'h0000_0043; #1;
        n_cmp++; if ({flush, stall, WBID, MEID, EXID} !== 11'b10_00_000_0000) begin n_bad++; $display("FAIL br_same got %b exp 10000000000", {flush, stall, WBID, MEID, EXID}); end
        tick();
        branch_taken = 1'b0; #1;
        n_cmp++; if ({imem_addr, instr} !== {10'd16, 32'h0}) begin n_bad++; $display("FAIL br_next got addr %h instr %h exp 10 0", imem_addr, instr); end
        n_cmp++; if ({flush, WBID, MEID, EXID} !== 10'b0) begin n_bad++; $display("FAIL br_next_ctrl got %b exp 0", {flush, WBID, MEID, EXID}); end
        tick();
        n_cmp++; if ({WBID, MEID, EXID} !== 9'b11_000_0100) begin n_bad++; $display("FAIL br_land_ctrl got %b exp 110000100", {WBID, MEID, EXID}); end
        n_cmp++; if (pc_id !== 32'h44) begin n_bad++; $display("FAIL br_land_pc_id got %h exp 44", pc_id); end
        tick();
        n_cmp++; if ({WBID, MEID, EXID} !== 9'b00_100_0010) begin n_bad++; $display("FAIL beq_ctrl got %b exp 001000010", {WBID, MEID, EXID}); end
        ex_mem_read = 1'b1; ex_rt = 5'd2; #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL beq_rt got %b exp 1", stall); end
        ex_mem_read = 1'b0;
        tick();
        ex_mem_read = 1'b1; #1;
        n_cmp++; if ({stall, WBID, MEID, EXID} !== 10'b0) begin n_bad++; $display("FAIL unk_ctrl got %b exp 0", {stall, WBID, MEID, EXID}); end
    endtask

    task automatic test_branch_hazard();
        ex_mem_read = 1'b1; ex_rt = 5'd1; #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL unk_rs got %b exp 1", stall); end
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC; #1;
        n_cmp++; if ({stall, flush} !== 2'b01) begin n_bad++; $display("FAIL brhz_prio got %b exp 01", {stall, flush}); end
        tick();
        branch_taken = 1'b0; ex_mem_read = 1'b0; #1;
        n_cmp++; if ({imem_addr, instr} !== {10'h3FF, 32'h0}) begin n_bad++; $display("FAIL brhz_next got addr %h instr %h exp 3ff 0", imem_addr, instr); end
        tick();
        n_cmp++; if (instr !== 32'h8C220004) begin n_bad++; $display("FAIL wrap_instr got %h exp 8c220004", instr); end
        n_cmp++; if ({pc_id, 22'd0, imem_addr} !== {32'd0, 32'd0}) begin n_bad++; $display("FAIL wrap_pc got pc_id %h addr %h exp 0 0", pc_id, imem_addr); end
    endtask

    task automatic test_reset_mid_stall();
        tick();
        ex_mem_read = 1'b1; ex_rt = 5'd1; #1;
        n_cmp++; if ({stall, imem_addr} !== {1'b1, 10'd1}) begin n_bad++; $display("FAIL rst_pre got stall %b addr %h exp 1 1", stall, imem_addr); end
        rst_n = 1'b0;
        tick();
        n_cmp++; if ({imem_addr, instr, pc_id} !== {10'd0, 32'h0, 32'h0}) begin n_bad++; $display("FAIL rst_mid_state got addr %h instr %h pc_id %h exp 0", imem_addr, instr, pc_id); end
        n_cmp++; if ({stall, WBID, MEID, EXID} !== 10'b0) begin n_bad++; $display("FAIL rst_mid_ctrl got %b exp 0", {stall, WBID, MEID, EXID}); end
        ex_mem_read = 1'b0; rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0]    = 32'h00221820;
        mem[1]    = 32'h8C220004;
        mem[2]    = 32'h20A20001;
        mem[3]    = 32'hAC220008;
        mem[16]   = 32'h00221820;
        mem[17]   = 32'h10220003;
        mem[18]   = 32'hFC220000;
        mem[1023] = 32'h8C220004;
        test_reset();
        test_fetch_decode();
        test_load_use();
        test_addi_store_hazard();
        test_branch();
        test_branch_hazard();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
